// File: rtl/ctr_retire_align.sv
// Pairs the n-th retirement of copy 1 with the n-th retirement of copy 2.
// Each side has a small FIFO; a side with an empty queue can feed the pair directly from its input.
module ctr_retire_align #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          retire_1_i,
    input  logic          retire_2_i,
    input  logic [31:0]   instr_1_i,
    input  logic [31:0]   reg_rs1_1_i,
    input  logic [31:0]   reg_rs2_1_i,
    input  logic [31:0]   reg_rd_1_i,
    input  logic [31:0]   mem_addr_1_i,
    input  logic [31:0]   mem_r_data_1_i,
    input  logic [31:0]   mem_w_data_1_i,
    input  logic [31:0]   instr_2_i,
    input  logic [31:0]   reg_rs1_2_i,
    input  logic [31:0]   reg_rs2_2_i,
    input  logic [31:0]   reg_rd_2_i,
    input  logic [31:0]   mem_addr_2_i,
    input  logic [31:0]   mem_r_data_2_i,
    input  logic [31:0]   mem_w_data_2_i,
    output logic          retire_o,
    output logic [31:0]   instr_1_o,
    output logic [31:0]   reg_rs1_1_o,
    output logic [31:0]   reg_rs2_1_o,
    output logic [31:0]   reg_rd_1_o,
    output logic [31:0]   mem_addr_1_o,
    output logic [31:0]   mem_r_data_1_o,
    output logic [31:0]   mem_w_data_1_o,
    output logic [31:0]   instr_2_o,
    output logic [31:0]   reg_rs1_2_o,
    output logic [31:0]   reg_rs2_2_o,
    output logic [31:0]   reg_rd_2_o,
    output logic [31:0]   mem_addr_2_o,
    output logic [31:0]   mem_r_data_2_o,
    output logic [31:0]   mem_w_data_2_o,
    output logic [CW-1:0] pending_1_o,
    output logic [CW-1:0] pending_2_o,
    output logic          overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    typedef logic [223:0] rec_t;

    rec_t          in_rec_s [2];
    rec_t          head_s   [2];
    logic [1:0]    ret_s;
    logic [1:0]    nonempty_s;
    logic [1:0]    avail_s;
    logic [1:0]    push_s;
    logic [1:0]    pop_s;
    logic          pair_s;

    rec_t          mem_q [2][DEPTH];
    rec_t          out_q [2];
    rec_t          out_d [2];
    logic [AW-1:0] rd_q  [2];
    logic [AW-1:0] rd_d  [2];
    logic [AW-1:0] wr_q  [2];
    logic [AW-1:0] wr_d  [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          retire_q, retire_d;
    logic          overflow_q, overflow_d;

    assign ret_s       = {retire_2_i, retire_1_i};
    assign in_rec_s[0] = {instr_1_i, reg_rs1_1_i, reg_rs2_1_i, reg_rd_1_i,
                          mem_addr_1_i, mem_r_data_1_i, mem_w_data_1_i};
    assign in_rec_s[1] = {instr_2_i, reg_rs1_2_i, reg_rs2_2_i, reg_rd_2_i,
                          mem_addr_2_i, mem_r_data_2_i, mem_w_data_2_i};

    // Pairing, push/pop decisions and next-state for queues and output register
    always_comb begin
        retire_d   = 1'b0;
        overflow_d = overflow_q;
        pair_s     = 1'b0;
        push_s     = 2'b00;
        pop_s      = 2'b00;
        nonempty_s = 2'b00;
        avail_s    = 2'b00;
        for (int k = 0; k < 2; k++) begin
            out_d[k]      = out_q[k];
            head_s[k]     = mem_q[k][rd_q[k]];
            nonempty_s[k] = (cnt_q[k] != {CW{1'b0}});
            avail_s[k]    = nonempty_s[k] | ret_s[k];
        end
        pair_s = avail_s[0] & avail_s[1];
        for (int k = 0; k < 2; k++) begin
            if (pair_s) begin
                retire_d = 1'b1;
                if (nonempty_s[k]) begin
                    out_d[k] = head_s[k];
                    pop_s[k] = 1'b1;
                end else begin
                    out_d[k] = in_rec_s[k];
                end
            end else begin
                out_d[k] = out_q[k];
            end
            // A record consumed by bypass never enters the queue; a full queue without a pop drops it.
            if (ret_s[k] && !(pair_s && !nonempty_s[k])) begin
                if ((cnt_q[k] == CW'(DEPTH)) && !pop_s[k]) begin
                    overflow_d = 1'b1;
                end else begin
                    push_s[k] = 1'b1;
                end
            end else begin
                push_s[k] = 1'b0;
            end
            rd_d[k]  = pop_s[k]  ? rd_q[k] + AW'(1'b1) : rd_q[k];
            wr_d[k]  = push_s[k] ? wr_q[k] + AW'(1'b1) : wr_q[k];
            cnt_d[k] = cnt_q[k] + CW'(push_s[k]) - CW'(pop_s[k]);
        end
    end

    // Control state and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            retire_q   <= 1'b0;
            overflow_q <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                out_q[k] <= '0;
                rd_q[k]  <= '0;
                wr_q[k]  <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            retire_q   <= retire_d;
            overflow_q <= overflow_d;
            for (int k = 0; k < 2; k++) begin
                out_q[k] <= out_d[k];
                rd_q[k]  <= rd_d[k];
                wr_q[k]  <= wr_d[k];
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Queue storage; entries are only read while the count says they are valid
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 2; k++) begin
            if (push_s[k]) begin
                mem_q[k][wr_q[k]] <= in_rec_s[k];
            end
        end
    end

    assign retire_o    = retire_q;
    assign overflow_o  = overflow_q;
    assign pending_1_o = cnt_q[0];
    assign pending_2_o = cnt_q[1];
    assign {instr_1_o, reg_rs1_1_o, reg_rs2_1_o, reg_rd_1_o,
            mem_addr_1_o, mem_r_data_1_o, mem_w_data_1_o} = out_q[0];
    assign {instr_2_o, reg_rs1_2_o, reg_rs2_2_o, reg_rd_2_o,
            mem_addr_2_o, mem_r_data_2_o, mem_w_data_2_o} = out_q[1];

endmodule
